seq_detect_010_1001: RTL and testbench

//   Serial bit-stream pattern detector. Samples one input bit per clock and

---
 rtl/seq_detect_010_1001.sv | 57 +++++
 tb/tb_seq_detect_010_1001.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_010_1001.sv
// Serial detector for "010" and "1001" with overlap; Mealy output valid in the
// same cycle as the completing bit.
module seq_detect_010_1001 (
    input  logic clk,
    input  logic reset_n,
    input  logic x,
    output logic out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S01  = 3'd3,
        S10  = 3'd4,
        S100 = 3'd5
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each state is the longest stream suffix that is still a pattern prefix.
    always_comb begin
        state_d = IDLE;
        out     = 1'b0;
        case (state_q)
            IDLE: state_d = x ? S1 : S0;
            S0:   state_d = x ? S01 : S0;
            S1:   state_d = x ? S1 : S10;
            S01: begin
                state_d = x ? S1 : S10;
                out     = ~x;
            end
            S10:  state_d = x ? S01 : S100;
            S100: begin
                state_d = x ? S01 : S0;
                out     = x;
            end
            default: begin
                state_d = IDLE;
                out     = 1'b0;
            end
        endcase
        // x may be unknown while in reset, so the flag is gated explicitly.
        if (!reset_n) begin
            out = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_010_1001.sv
// Directed-vector bench for seq_detect_010_1001: x driven on negedge, out
// sampled 1 time unit before the capturing posedge.
module tb_seq_detect_010_1001;

    logic clk;
    logic reset_n;
    logic x;
    logic out;

    int unsigned tests;
    int unsigned fails;

    seq_detect_010_1001 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit on the negedge and stop just before the next posedge.
    task automatic apply(input logic b, input logic rn);
        @(negedge clk);
        x       = b;
        reset_n = rn;
        #4;
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(1'bx, 1'b0);
        tests++;
        if (out !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_x: got %b want 0", out);
        end
        // From IDLE a single 0 must not flag; a stale S01 would.
        apply(1'b0, 1'b1);
        tests++;
        if (out !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_first0: got %b want 0", out);
        end
        apply(1'b1, 1'b1);
        apply(1'b0, 1'b1);
        tests++;
        if (out !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_010: got %b want 1", out);
        end
    endtask

    task automatic test_stream();
        logic [16:0] bits;
        logic [16:0] expv;
        // index 0 = bit 1
        bits = 17'b0_1100_1000_1001_0100;
        expv = 17'b0_0101_0001_1010_1000;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(bits[i], 1'b1);
            tests++;
            if (out !== expv[i]) begin
                fails++;
                $display("FAIL stream_bit%0d: got %b want %b", i + 1, out, expv[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] expv;
        bits = 7'b0101001;
        expv = 7'b1011000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(bits[i], 1'b1);
            tests++;
            if (out !== expv[i]) begin
                fails++;
                $display("FAIL overlap_bit%0d: got %b want %b", i + 1, out, expv[i]);
            end
        end
    endtask

    task automatic test_no_match();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1);
            tests++;
            if (out !== 1'b0) begin
                fails++;
                $display("FAIL ones_bit%0d: got %b want 0", i + 1, out);
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1);
            tests++;
            if (out !== 1'b0) begin
                fails++;
                $display("FAIL zeros_bit%0d: got %b want 0", i + 1, out);
            end
        end
    endtask

    task automatic test_reset_mid_match();
        do_reset();
        apply(1'b1, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        // Now in S100: x=1 would complete "1001" if reset were ignored.
        apply(1'b1, 1'b0);
        tests++;
        if (out !== 1'b0) begin
            fails++;
            $display("FAIL midreset_during: got %b want 0", out);
        end
        apply(1'b1, 1'b1);
        tests++;
        if (out !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after1: got %b want 0", out);
        end
        apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        tests++;
        if (out !== 1'b0) begin
            fails++;
            $display("FAIL midreset_01: got %b want 0", out);
        end
        apply(1'b0, 1'b1);
        tests++;
        if (out !== 1'b1) begin
            fails++;
            $display("FAIL midreset_010: got %b want 1", out);
        end
    endtask

    task automatic test_reset_held();
        logic [4:0] bits;
        bits = 5'b10010;
        // Enter S01 so the first x=0 under reset would otherwise flag.
        do_reset();
        apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(bits[i], 1'b0);
            tests++;
            if (out !== 1'b0) begin
                fails++;
                $display("FAIL held_reset_bit%0d: got %b want 0", i + 1, out);
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        x       = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_stream();
        test_overlap();
        test_no_match();
        test_reset_mid_match();
        test_reset_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
